opv_macromodel_mc: RTL and testbench
====================================

# opv_macromodel_mc

Multi-channel, time-multiplexed discrete-time behavioural macromodel of a single-pole operational amplifier stage. Each sample produces an amplified differential input with programmable gain, rail clamping, a first-order pole (one-pole IIR) and slew-rate limiting. The block replaces per-instance analog op-amp test fixtures in mixed-signal gain benches: one instance serves `CH` independent amplifier channels through a valid/ready sample stream.

## Interface
- `W`, 16: signed sample width (two's complement).
- `CH`, 4: number of channels; power of two, ≥2.
- `K_SH`, 4: pole shift; the per-update pole coefficient is 2^-K_SH.
- `SLEW`, 512: maximum absolute output change per update, in LSB; must be >0.
- `VPOS`, 28672: positive rail, in LSB.
- `VNEG`, -28672: negative rail, in LSB; VNEG < 0 < VPOS.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous clear of all channel state and pipeline.
- `gain`  in  8  unsigned Q4.4 closed-loop gain; 0x10 = 1.0.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  input accepted when `in_valid && in_ready`.
- `in_ch`  in  log2(CH)  channel index.
- `in_p`  in  W  signed non-inverting input.
- `in_n`  in  W  signed inverting input.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_ch`  out  log2(CH)  channel of the output sample.
- `out_data`  out  W  signed model output.
- `out_sat`  out  1  rail clamp or slew limit was applied to this sample.

## Operation
- Per-channel state `y[ch]` (W bits), reset/clear to 0; always within [VNEG, VPOS].
- Stage 1, on accept: `e = in_p - in_n` (W+1 bits, exact); `prod = e * gain` (gain zero-extended, exact); `t = prod >>> 4`; `target = clamp(t, VNEG, VPOS)`; `rclip = (t != target)`. Register `ch`, `target` and `rclip`; `gain` is sampled only at accept.
- Stage 2, on advance: `d = target - y[ch]` (W+1 bits); `s = d >>> K_SH` (arithmetic, floor); `step = clamp(s, -SLEW, SLEW)`; `sclip = (s != step)`; `ynew = clamp(y[ch] + step, VNEG, VPOS)`.
- Stage 2 writes `ynew` to `y[ch]` and to `out_data`, sets `out_ch = ch` and `out_sat = rclip | sclip`.
- The read-modify-write of `y` completes in the advancing cycle, so back-to-back samples on the same channel see the updated state. No forwarding hazard exists.
- Channels are fully independent; samples on one channel never alter another channel's state.

## Timing
- `advance = !out_valid || out_ready`; `in_ready = advance && !clr` (combinational).
- Global stall: when `advance` is 0, stage 1, stage 2, `y` and all outputs hold.
- Latency: a sample accepted at edge k gives `out_valid = 1` with its result after edge k+1. Full throughput is one sample per cycle.
- `out_data`, `out_ch` and `out_sat` are stable while `out_valid && !out_ready`.
- `clr = 1` at an edge:
  - every `y` becomes 0;
  - the stage-1 valid and `out_valid` become 0;
  - an in-flight sample is discarded;
  - no input is accepted in that cycle.
- Reset (async assert, any time including mid-stream) sets:
  - `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `out_sat = 0`;
  - the stage-1 valid to 0;
  - all `y` to 0.
  - After reset, `in_ready = 1`.
- Simultaneous `clr` and `rst_n` low: reset wins.

## Test plan
- Reset then ch0, `in_p = 1000`, `in_n = 0`, `gain = 0x10` → two edges later: `out_valid = 1`, `out_ch = 0`, `out_data = 62`, `out_sat = 0`.
- Repeat the same ch0 sample immediately (back-to-back) → `out_data = 120` (62 + 938>>>4). A ch1 sample interleaved between them → ch1 `out_data = 62`, ch0 unaffected.
- ch2, `in_p = 0`, `in_n = 1000`, `gain = 0x10` → `out_data = -63` (floor rounding), `out_sat = 0`.
- ch3, `in_p = 10000`, `gain = 0x40` → `t = 40000` clamped to 28672, step limited to 512: `out_data = 512`, `out_sat = 1`. Repeating 10 times → outputs 1024, 1536, … 5120, each with `out_sat = 1`.
- Hold `out_ready = 0` for 5 cycles while `in_valid` stays high → `in_ready = 0`, outputs frozen. On release, every sample emerges exactly once, in order.
- Assert `clr` mid-stream, then `rst_n` low mid-stream → no output from the discarded sample. The next ch0 sample (`in_p = 1000`, gain 1.0) yields 62 again.

Source files
------------

// File: rtl/opv_macromodel_mc_if.sv
// Sample stream bundle for opv_macromodel_mc: differential input samples with gain,
// amplified/filtered output samples; valid/ready on both sides.
interface opv_macromodel_mc_if #(
  parameter int W  = 16,
  parameter int CH = 4
) ();
  localparam int CW = $clog2(CH);

  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        in_ch;
  logic signed [W-1:0]  in_p;
  logic signed [W-1:0]  in_n;
  logic [7:0]           gain;

  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_ch;
  logic signed [W-1:0]  out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_ch, in_p, in_n, gain, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_p, in_n, gain, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/opv_macromodel_mc.sv
// Time-multiplexed single-pole op-amp macromodel: gain, rail clamp, one-pole IIR, slew limit.
// Latency 2 edges accept-to-output, one sample per cycle.
// Backpressure: out_ready low stalls the whole pipeline and the per-channel state.
module opv_macromodel_mc #(
  parameter int W    = 16,
  parameter int CH   = 4,
  parameter int K_SH = 4,
  parameter int SLEW = 512,
  parameter int VPOS = 28672,
  parameter int VNEG = -28672
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  opv_macromodel_mc_if.slave   bus
);
  localparam int CW = $clog2(CH);
  localparam int PW = W + 10;
  localparam int DW = W + 1;
  localparam int SW = W + 2;

  localparam logic signed [PW-1:0] VPOS_P = PW'(VPOS);
  localparam logic signed [PW-1:0] VNEG_P = PW'(VNEG);
  localparam logic signed [W-1:0]  VPOS_W = W'(VPOS);
  localparam logic signed [W-1:0]  VNEG_W = W'(VNEG);
  localparam logic signed [SW-1:0] VPOS_S = SW'(VPOS);
  localparam logic signed [SW-1:0] VNEG_S = SW'(VNEG);
  localparam logic signed [DW-1:0] SLEW_P = DW'(SLEW);
  localparam logic signed [DW-1:0] SLEW_N = DW'(-SLEW);

  logic                 s1_vld;
  logic [CW-1:0]        s1_ch;
  logic signed [W-1:0]  s1_target;
  logic                 s1_rclip;

  logic                 s2_vld;
  logic [CW-1:0]        s2_ch;
  logic signed [W-1:0]  s2_dat;
  logic                 s2_sat;

  logic signed [W-1:0]  y [CH];

  logic advance;
  logic accept;

  assign advance       = !s2_vld || bus.out_ready;
  assign bus.in_ready  = advance && !clr;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = s2_vld;
  assign bus.out_ch    = s2_ch;
  assign bus.out_data  = s2_dat;
  assign bus.out_sat   = s2_sat;

  // Stage 1: exact differential gain, then rail clamp of the settled target.
  logic signed [DW-1:0] e;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] t;
  logic signed [W-1:0]  target;
  logic                 rclip;

  always_comb begin
    e      = {bus.in_p[W-1], bus.in_p} - {bus.in_n[W-1], bus.in_n};
    prod   = PW'(e) * PW'($signed({1'b0, bus.gain}));
    t      = prod >>> 4;
    target = t[W-1:0];
    rclip  = 1'b0;
    if (t > VPOS_P) begin
      target = VPOS_W;
      rclip  = 1'b1;
    end else if (t < VNEG_P) begin
      target = VNEG_W;
      rclip  = 1'b1;
    end
  end

  // Stage 2: pole step toward the target, slew-limited, result kept inside the rails.
  logic signed [W-1:0]  ycur;
  logic signed [DW-1:0] d;
  logic signed [DW-1:0] s;
  logic signed [DW-1:0] step;
  logic                 sclip;
  logic signed [SW-1:0] sum;
  logic signed [W-1:0]  ynew;

  always_comb begin
    ycur  = y[s1_ch];
    d     = {s1_target[W-1], s1_target} - {ycur[W-1], ycur};
    s     = d >>> K_SH;
    step  = s;
    sclip = 1'b0;
    if (s > SLEW_P) begin
      step  = SLEW_P;
      sclip = 1'b1;
    end else if (s < SLEW_N) begin
      step  = SLEW_N;
      sclip = 1'b1;
    end
    sum  = {{2{ycur[W-1]}}, ycur} + {step[DW-1], step};
    ynew = sum[W-1:0];
    if (sum > VPOS_S) begin
      ynew = VPOS_W;
    end else if (sum < VNEG_S) begin
      ynew = VNEG_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_ch     <= '0;
      s1_target <= '0;
      s1_rclip  <= 1'b0;
      s2_vld    <= 1'b0;
      s2_ch     <= '0;
      s2_dat    <= '0;
      s2_sat    <= 1'b0;
      for (int i = 0; i < CH; i++) y[i] <= '0;
    end else if (clr) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      for (int i = 0; i < CH; i++) y[i] <= '0;
    end else if (advance) begin
      s1_vld <= accept;
      if (accept) begin
        s1_ch     <= bus.in_ch;
        s1_target <= target;
        s1_rclip  <= rclip;
      end
      s2_vld <= s1_vld;
      // State is written in the same cycle it is read, so a following
      // sample on the same channel already sees the update.
      if (s1_vld) begin
        y[s1_ch] <= ynew;
        s2_ch    <= s1_ch;
        s2_dat   <= ynew;
        s2_sat   <= s1_rclip | sclip;
      end
    end
  end
endmodule

// File: tb/tb_opv_macromodel_mc.sv
// Directed-vector bench for opv_macromodel_mc; expected values are hand-computed
// from the macromodel equations (gain, clamp, >>>4 pole step, +/-512 slew).
module tb_opv_macromodel_mc;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int q_ch[$];
  int q_dat[$];
  int q_sat[$];

  always #5 clk = ~clk;

  opv_macromodel_mc_if #(.W(16), .CH(4)) bus ();

  opv_macromodel_mc #(
    .W(16), .CH(4), .K_SH(4), .SLEW(512), .VPOS(28672), .VNEG(-28672)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  // Output transfers captured mid-cycle; a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_ch.push_back(int'(bus.out_ch));
      q_dat.push_back(int'($signed(bus.out_data)));
      q_sat.push_back(int'(bus.out_sat));
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int ch, input int p, input int n, input int g);
    bus.in_valid = v;
    bus.in_ch    = 2'(ch);
    bus.in_p     = 16'(p);
    bus.in_n     = 16'(n);
    bus.gain     = 8'(g);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int p, input int n, input int g);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    drive(1'b1, ch, p, n, g);
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input int ch, input int dat, input int sat);
    int n;
    n = 0;
    while (q_dat.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    if (q_dat.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_ch"},  q_ch.pop_front(),  ch);
      chk({tag, "_dat"}, q_dat.pop_front(), dat);
      chk({tag, "_sat"}, q_sat.pop_front(), sat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 0, 0, 0, 16);
    bus.out_ready = 1'b1;
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  $signed(bus.out_data), 0);
    chk("rst_out_ch",    bus.out_ch, 0);
    chk("rst_out_sat",   bus.out_sat, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // First sample and its two-edge latency.
    send(0, 1000, 0, 16);
    idle();
    chk("lat_edge_k",  bus.out_valid, 0);
    tick();
    chk("lat_edge_k1", bus.out_valid, 1);
    chk("lat_data",    $signed(bus.out_data), 62);
    expect_out("ch0_first", 0, 62, 0);

    // Back-to-back on ch0 with ch1 interleaved.
    send(0, 1000, 0, 16);
    send(1, 1000, 0, 16);
    send(0, 1000, 0, 16);
    send(0, 1000, 0, 16);
    idle();
    expect_out("ch0_second", 0, 120, 0);
    expect_out("ch1_first",  1, 62,  0);
    expect_out("ch0_third",  0, 175, 0);
    expect_out("ch0_fourth", 0, 226, 0);

    // Negative input, floor rounding of the pole step.
    send(2, 0, 1000, 16);
    idle();
    expect_out("ch2_floor", 2, -63, 0);

    // Rail clamp plus slew limit, repeated.
    for (int i = 0; i < 10; i++) send(3, 10000, 0, 64);
    idle();
    for (int i = 0; i < 10; i++) expect_out("ch3_slew", 3, 512 * (i + 1), 1);

    // Negative rail and negative slew.
    send(2, -20000, 20000, 16);
    idle();
    expect_out("ch2_negrail", 2, -575, 1);

    // Zero gain pulls toward 0 with floor rounding.
    send(1, 5000, 0, 0);
    idle();
    expect_out("ch1_gain0", 1, 58, 0);
    tick();
    tick();

    // Backpressure: five stalled cycles, then ordered drain.
    send(1, 1000, 0, 16);
    bus.out_ready = 1'b0;
    send(0, 1000, 0, 16);
    drive(1'b1, 1, 1000, 0, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_valid",    bus.out_valid, 1);
      chk("stall_data",     $signed(bus.out_data), 116);
      chk("stall_ch",       bus.out_ch, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    send(1, 1000, 0, 16);
    idle();
    expect_out("drain_a", 1, 116, 0);
    expect_out("drain_b", 0, 274, 0);
    expect_out("drain_c", 1, 171, 0);
    repeat (3) tick();
    chk("drain_no_extra", q_dat.size(), 0);

    // Clear with one sample in flight and another offered.
    send(0, 1000, 0, 16);
    drive(1'b1, 1, 1000, 0, 16);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", bus.in_ready, 0);
    tick();
    clr = 1'b0;
    idle();
    chk("clr_out_valid", bus.out_valid, 0);
    repeat (4) tick();
    chk("clr_no_output", q_dat.size(), 0);
    send(0, 1000, 0, 16);
    send(3, 10000, 0, 64);
    idle();
    expect_out("clr_ch0", 0, 62,  0);
    expect_out("clr_ch3", 3, 512, 1);

    // Asynchronous reset mid-stream with a result presented and one in flight.
    send(2, 5000, 0, 16);
    send(2, 5000, 0, 16);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    idle();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data",  $signed(bus.out_data), 0);
    chk("midrst_out_ch",    bus.out_ch, 0);
    chk("midrst_out_sat",   bus.out_sat, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    repeat (2) tick();
    chk("rst_no_output", q_dat.size(), 0);
    send(0, 1000, 0, 16);
    send(2, 5000, 0, 16);
    idle();
    expect_out("rst_ch0", 0, 62,  0);
    expect_out("rst_ch2", 2, 312, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
